// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared MIPS pipeline constants. The decode stage and the write-back stage
// both import this package. Keeping the encodings here means the two stages
// always agree on them.
//
// Contents:
//   wb_src_e    : write-back source select (ALU / MEM / LINK; 2'b11 aliases ALU)
//   mem_size_e  : load size (BYTE / HALF / WORD; 2'b11 aliases WORD)
//   LINK_OFFSET : byte distance from a jump-and-link to its return address
//                 (the branch delay slot sits in between)
// -----------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [1:0] {
    WB_SRC_ALU     = 2'b00,
    WB_SRC_MEM     = 2'b01,
    WB_SRC_LINK    = 2'b10,
    WB_SRC_ALU_ALT = 2'b11
  } wb_src_e;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE     = 2'b00,
    MEM_SIZE_HALF     = 2'b01,
    MEM_SIZE_WORD     = 2'b10,
    MEM_SIZE_WORD_ALT = 2'b11
  } mem_size_e;

  // The return address skips the delay slot: pc + 8.
  localparam int unsigned LINK_OFFSET = 8;

endpackage : mips_pkg

// File: rtl/load_extract.sv
// -----------------------------------------------------------------------------
// load_extract
// This is a purely combinational block. It picks the addressed byte or
// halfword out of a raw little-endian memory word. It then sign-extends or
// zero-extends that value to the full bus width. A word load passes the
// whole bus through unchanged.
//
// Ports:
//   i_data     [IO_BUS_SIZE-1:0] raw data-memory word
//   i_size     [1:0]             load size (mem_size_e encoding)
//   i_unsigned                   1 = zero-extend, 0 = sign-extend
//   i_offset   [1:0]             load address bits [1:0]
//   o_data     [IO_BUS_SIZE-1:0] extracted, extended load data
// -----------------------------------------------------------------------------
module load_extract
  import mips_pkg::*;
#(
  parameter int unsigned IO_BUS_SIZE = 32
) (
  input  logic [IO_BUS_SIZE-1:0] i_data,
  input  logic [1:0]             i_size,
  input  logic                   i_unsigned,
  input  logic [1:0]             i_offset,
  output logic [IO_BUS_SIZE-1:0] o_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        byte_fill;
  logic        half_fill;

  // Lanes are always taken from the low 32 bits, even on a wider bus.
  // A halfword ignores offset bit 0. Misaligned halfwords are not trapped.
  assign byte_lane = i_data[{i_offset, 3'b000} +: 8];
  assign half_lane = i_data[{i_offset[1], 4'b0000} +: 16];

  assign byte_fill = ~i_unsigned & byte_lane[7];
  assign half_fill = ~i_unsigned & half_lane[15];

  always_comb begin
    // NOTE: assign a default before the case. Then every path drives o_data,
    // and no latch is inferred.
    o_data = i_data;
    case (mem_size_e'(i_size))
      MEM_SIZE_BYTE: o_data = {{(IO_BUS_SIZE - 8){byte_fill}}, byte_lane};
      MEM_SIZE_HALF: o_data = {{(IO_BUS_SIZE - 16){half_fill}}, half_lane};
      default:       o_data = i_data;  // word: offset and signedness ignored
    endcase
  end

endmodule : load_extract

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// MIPS MEM/WB pipeline register and write-back source mux. The block selects
// one result: the ALU result, the extracted load data, or the link address
// (pc + 8). It registers that result together with the destination register
// and a qualified write enable. It also counts retired instructions.
//
// Register update priority on every rising edge: reset > flush > stall > load.
//   flush : load a bubble (en/addr/data = 0). The counter is unchanged.
//   stall : hold every output, including the counter.
//   load  : capture the selected data and i_rd. The write enable is set only
//           for a valid, register-writing instruction whose rd is not $zero.
//           Every valid instruction is counted, whether or not it writes.
//
// Ports:
//   i_clk, i_reset                    clock and synchronous active-high reset
//   i_stall, i_flush                  pipeline hold / bubble insert
//   i_valid, i_reg_write              instruction qualifiers
//   i_wb_src [1:0]                    write-back source (wb_src_e)
//   i_mem_size [1:0], i_mem_unsigned  load size / extension
//   i_byte_offset [1:0]               load address bits [1:0]
//   i_alu_result, i_mem_result, i_pc  [IO_BUS_SIZE-1:0] data inputs
//   i_rd [REG_ADDR_SIZE-1:0]          destination register
//   o_wb_data, o_wb_addr, o_wb_en     registered write-back port
//   o_retired [RETIRE_CNT_SIZE-1:0]   retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module wb_stage
  import mips_pkg::*;
#(
  parameter int unsigned IO_BUS_SIZE     = 32,
  parameter int unsigned REG_ADDR_SIZE   = 5,
  parameter int unsigned RETIRE_CNT_SIZE = 32
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_stall,
  input  logic                       i_flush,
  input  logic                       i_valid,
  input  logic                       i_reg_write,
  input  logic [1:0]                 i_wb_src,
  input  logic [1:0]                 i_mem_size,
  input  logic                       i_mem_unsigned,
  input  logic [1:0]                 i_byte_offset,
  input  logic [IO_BUS_SIZE-1:0]     i_alu_result,
  input  logic [IO_BUS_SIZE-1:0]     i_mem_result,
  input  logic [IO_BUS_SIZE-1:0]     i_pc,
  input  logic [REG_ADDR_SIZE-1:0]   i_rd,
  output logic [IO_BUS_SIZE-1:0]     o_wb_data,
  output logic [REG_ADDR_SIZE-1:0]   o_wb_addr,
  output logic                       o_wb_en,
  output logic [RETIRE_CNT_SIZE-1:0] o_retired
);

  logic [IO_BUS_SIZE-1:0] load_data;
  logic [IO_BUS_SIZE-1:0] link_addr;
  logic [IO_BUS_SIZE-1:0] sel_data;
  logic                   wb_en_next;

  load_extract #(
    .IO_BUS_SIZE(IO_BUS_SIZE)
  ) u_load_extract (
    .i_data    (i_mem_result),
    .i_size    (i_mem_size),
    .i_unsigned(i_mem_unsigned),
    .i_offset  (i_byte_offset),
    .o_data    (load_data)
  );

  // The carry out is dropped, so the link address wraps modulo 2^IO_BUS_SIZE.
  assign link_addr = i_pc + IO_BUS_SIZE'(LINK_OFFSET);

  always_comb begin
    sel_data = i_alu_result;
    case (wb_src_e'(i_wb_src))
      WB_SRC_MEM:  sel_data = load_data;
      WB_SRC_LINK: sel_data = link_addr;
      default:     sel_data = i_alu_result;  // ALU and its 2'b11 alias
    endcase
  end

  // Writes to $zero are dropped here, so the register file needs no guard.
  assign wb_en_next = i_valid & i_reg_write & (i_rd != '0);

  // NOTE: use non-blocking assignments for all registered state. Every
  // register then samples the pre-edge values, so the outcome does not
  // depend on statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_wb_data <= '0;
      o_wb_addr <= '0;
      o_wb_en   <= 1'b0;
      o_retired <= '0;
    end else if (i_flush) begin
      // A bubble wins over a stall. The instruction being flushed is not
      // counted.
      o_wb_data <= '0;
      o_wb_addr <= '0;
      o_wb_en   <= 1'b0;
    end else if (!i_stall) begin
      o_wb_data <= sel_data;
      o_wb_addr <= i_rd;
      o_wb_en   <= wb_en_next;
      if (i_valid) begin
        o_retired <= o_retired + RETIRE_CNT_SIZE'(1);
      end
    end
  end

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
// Directed test for wb_stage. A behavioural model steps alongside the DUT
// and is compared with it on every falling edge. Hand-computed literal
// checks at key points pin the model itself. A second instance with a 4-bit
// retire counter shares the same stimulus; it is used for the wrap case.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_stall;
  logic        i_flush;
  logic        i_valid;
  logic        i_reg_write;
  logic [1:0]  i_wb_src;
  logic [1:0]  i_mem_size;
  logic        i_mem_unsigned;
  logic [1:0]  i_byte_offset;
  logic [31:0] i_alu_result;
  logic [31:0] i_mem_result;
  logic [31:0] i_pc;
  logic [4:0]  i_rd;

  logic [31:0] o_wb_data;
  logic [4:0]  o_wb_addr;
  logic        o_wb_en;
  logic [31:0] o_retired;

  logic [31:0] n_wb_data;
  logic [4:0]  n_wb_addr;
  logic        n_wb_en;
  logic [3:0]  n_retired;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  wb_stage dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush),
    .i_valid(i_valid), .i_reg_write(i_reg_write), .i_wb_src(i_wb_src),
    .i_mem_size(i_mem_size), .i_mem_unsigned(i_mem_unsigned),
    .i_byte_offset(i_byte_offset), .i_alu_result(i_alu_result),
    .i_mem_result(i_mem_result), .i_pc(i_pc), .i_rd(i_rd),
    .o_wb_data(o_wb_data), .o_wb_addr(o_wb_addr), .o_wb_en(o_wb_en),
    .o_retired(o_retired)
  );

  wb_stage #(.RETIRE_CNT_SIZE(4)) dut4 (
    .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush),
    .i_valid(i_valid), .i_reg_write(i_reg_write), .i_wb_src(i_wb_src),
    .i_mem_size(i_mem_size), .i_mem_unsigned(i_mem_unsigned),
    .i_byte_offset(i_byte_offset), .i_alu_result(i_alu_result),
    .i_mem_result(i_mem_result), .i_pc(i_pc), .i_rd(i_rd),
    .o_wb_data(n_wb_data), .o_wb_addr(n_wb_addr), .o_wb_en(n_wb_en),
    .o_retired(n_retired)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_data;
  longint m_addr;
  longint m_en;
  longint m_ret;
  longint m_ret4;
  bit     model_ok = 1'b0;

  localparam longint TWO32 = 64'h1_0000_0000;

  function automatic longint model_load();
    longint mem, off, v;
    mem = longint'(i_mem_result);
    off = longint'(i_byte_offset);
    if (i_mem_size == 2'd0) begin
      v = (mem >> (8 * off)) % 256;
      if (!i_mem_unsigned && v >= 128) v = v - 256 + TWO32;
    end else if (i_mem_size == 2'd1) begin
      v = (mem >> (16 * (off / 2))) % 65536;
      if (!i_mem_unsigned && v >= 32768) v = v - 65536 + TWO32;
    end else begin
      v = mem;
    end
    return v;
  endfunction

  function automatic longint model_select();
    if (i_wb_src == 2'd1) return model_load();
    if (i_wb_src == 2'd2) return (longint'(i_pc) + 8) % TWO32;
    return longint'(i_alu_result);
  endfunction

  always @(posedge i_clk) begin
    if (i_reset) begin
      m_data = 0; m_addr = 0; m_en = 0; m_ret = 0; m_ret4 = 0;
    end else if (i_flush) begin
      m_data = 0; m_addr = 0; m_en = 0;
    end else if (!i_stall) begin
      m_data = model_select();
      m_addr = longint'(i_rd);
      m_en   = (i_valid && i_reg_write && i_rd != 0) ? 1 : 0;
      if (i_valid) begin
        m_ret  = (m_ret + 1) % TWO32;
        m_ret4 = (m_ret4 + 1) % 16;
      end
    end
    model_ok = 1'b1;
  end

  always @(negedge i_clk) begin
    if (model_ok) begin
      check("cmp_data",    o_wb_data,         32'(m_data));
      check("cmp_addr",    32'(o_wb_addr),    32'(m_addr));
      check("cmp_en",      32'(o_wb_en),      32'(m_en));
      check("cmp_retired", o_retired,         32'(m_ret));
      check("cmp_ret4",    32'(n_retired),    32'(m_ret4));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_reset = 0; i_stall = 0; i_flush = 0; i_valid = 0; i_reg_write = 0;
    i_wb_src = 0; i_mem_size = 0; i_mem_unsigned = 0; i_byte_offset = 0;
    i_alu_result = 0; i_mem_result = 0; i_pc = 0; i_rd = 0;
  endtask

  task automatic randomize_inputs();
    i_stall = 1'($urandom); i_flush = 1'($urandom); i_valid = 1'($urandom);
    i_reg_write = 1'($urandom); i_wb_src = 2'($urandom);
    i_mem_size = 2'($urandom); i_mem_unsigned = 1'($urandom);
    i_byte_offset = 2'($urandom); i_alu_result = $urandom;
    i_mem_result = $urandom; i_pc = $urandom; i_rd = 5'($urandom);
  endtask

  task automatic mem_load(input logic [1:0] size, input logic uns,
                          input logic [1:0] off);
    idle();
    i_valid = 1; i_reg_write = 1; i_wb_src = 2'b01; i_rd = 5;
    i_mem_result = 32'h80FF7F01;
    i_mem_size = size; i_mem_unsigned = uns; i_byte_offset = off;
  endtask

  task automatic alu_load(input logic [31:0] v, input logic [4:0] rd);
    idle();
    i_valid = 1; i_reg_write = 1; i_wb_src = 2'b00;
    i_alu_result = v; i_rd = rd;
  endtask

  initial begin
    idle();

    // Reset with random inputs for two cycles.
    for (int c = 0; c < 2; c++) begin
      randomize_inputs();
      i_reset = 1;
      tick();
      check("rst_data", o_wb_data, 32'h0);
      check("rst_addr", 32'(o_wb_addr), 32'h0);
      check("rst_en", 32'(o_wb_en), 32'h0);
      check("rst_retired", o_retired, 32'h0);
    end

    // Loads from 0x80FF7F01.
    mem_load(2'b00, 1'b0, 2'd3); tick();
    check("lb_s3_data", o_wb_data, 32'hFFFFFF80);
    check("lb_s3_addr", 32'(o_wb_addr), 32'd5);
    check("lb_s3_en", 32'(o_wb_en), 32'd1);
    check("lb_s3_ret", o_retired, 32'd1);
    mem_load(2'b00, 1'b1, 2'd3); tick();
    check("lbu_3_data", o_wb_data, 32'h00000080);
    mem_load(2'b01, 1'b0, 2'd2); tick();
    check("lh_s2_data", o_wb_data, 32'hFFFF80FF);
    mem_load(2'b01, 1'b0, 2'd1); tick();
    check("lh_s1_data", o_wb_data, 32'h00007F01);
    mem_load(2'b10, 1'b1, 2'd3); tick();
    check("lw_data", o_wb_data, 32'h80FF7F01);

    // Link address wraps.
    idle();
    i_valid = 1; i_reg_write = 1; i_wb_src = 2'b10; i_pc = 32'hFFFFFFFC; i_rd = 31;
    tick();
    check("link_data", o_wb_data, 32'h00000004);
    check("link_en", 32'(o_wb_en), 32'd1);
    check("link_ret", o_retired, 32'd6);

    // Idle, invalid cycle: the counter holds.
    idle(); tick();
    check("idle_ret", o_retired, 32'd6);
    check("idle_en", 32'(o_wb_en), 32'd0);

    // Stall sequence from a fresh reset.
    idle(); i_reset = 1; tick();
    alu_load(32'h12345678, 5'd3); tick();
    check("stl_ld_ret", o_retired, 32'd1);
    alu_load(32'hDEADBEEF, 5'd3); i_stall = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stl_hold_data", o_wb_data, 32'h12345678);
      check("stl_hold_addr", 32'(o_wb_addr), 32'd3);
      check("stl_hold_en", 32'(o_wb_en), 32'd1);
      check("stl_hold_ret", o_retired, 32'd1);
    end
    i_stall = 0; tick();
    check("stl_rel_data", o_wb_data, 32'hDEADBEEF);
    check("stl_rel_ret", o_retired, 32'd2);

    // Flush wins over stall.
    alu_load(32'hCAFEF00D, 5'd4); i_flush = 1; i_stall = 1; tick();
    check("fl_en", 32'(o_wb_en), 32'd0);
    check("fl_data", o_wb_data, 32'h0);
    check("fl_addr", 32'(o_wb_addr), 32'h0);
    check("fl_ret", o_retired, 32'd2);

    // A write to rd=0 is suppressed but still retires.
    alu_load(32'h00000055, 5'd0); tick();
    check("rd0_en", 32'(o_wb_en), 32'd0);
    check("rd0_ret", o_retired, 32'd3);

    // Reset during a stall discards the held instruction.
    alu_load(32'hA5A5A5A5, 5'd7); tick();
    i_stall = 1; tick();
    i_reset = 1; tick();
    check("rstst_data", o_wb_data, 32'h0);
    check("rstst_ret", o_retired, 32'h0);
    alu_load(32'h0BADF00D, 5'd9); tick();
    check("rstst_rel_data", o_wb_data, 32'h0BADF00D);
    check("rstst_rel_en", 32'(o_wb_en), 32'd1);
    check("rstst_rel_ret", o_retired, 32'd1);

    // Counter wrap on the 4-bit instance.
    idle(); i_reset = 1; tick();
    for (int c = 0; c < 17; c++) begin
      idle(); i_valid = 1; i_alu_result = 32'(c * 3); i_rd = 5'(c);
      tick();
    end
    check("wrap_ret4", 32'(n_retired), 32'd1);
    check("wrap_ret32", o_retired, 32'd17);

    idle(); tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wb_stage

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameters: IO_BUS_SIZE, 32, data bus width (multiple of 8, >= 32); REG_ADDR_SIZE, 5, register-file address width; RETIRE_CNT_SIZE, 32, retired-instruction counter width.
REQ-002 SHALL have ports, in this order (name, direction, width, meaning):
- i_clk, in, 1: single clock, rising edge.
- i_reset, in, 1: synchronous, active-high reset.
- i_stall, in, 1: hold the MEM/WB register.
- i_flush, in, 1: load a bubble.
- i_valid, in, 1: MEM-stage instruction is valid.
- i_reg_write, in, 1: instruction writes the register file.
- i_wb_src, in, 2: write-back source select (00 ALU, 01 MEM, 10 LINK, 11 ALU).
- i_mem_size, in, 2: load size (00 byte, 01 half, 10 word, 11 word).
- i_mem_unsigned, in, 1: 1 zero-extends loads, 0 sign-extends.
- i_byte_offset, in, 2: load address bits [1:0].
- i_alu_result, in, IO_BUS_SIZE: ALU result.
- i_mem_result, in, IO_BUS_SIZE: raw data-memory word.
- i_pc, in, IO_BUS_SIZE: address of the instruction.
- i_rd, in, REG_ADDR_SIZE: destination register.
- o_wb_data, out, IO_BUS_SIZE: registered write-back data.
- o_wb_addr, out, REG_ADDR_SIZE: registered destination register.
- o_wb_en, out, 1: registered register-file write enable.
- o_retired, out, RETIRE_CNT_SIZE: retired-instruction count.
REQ-003 The design SHALL use one clock; reset SHALL be synchronous and active-high, with ports i_clk and i_reset.

Function
REQ-004 Selection SHALL be combinational: ALU passes i_alu_result; MEM passes extracted load data; LINK passes i_pc + 8 modulo 2^IO_BUS_SIZE.
REQ-005 Byte load SHALL take lane i_byte_offset, little-endian, bits [8k+7:8k] of the low 32 bits, extended to IO_BUS_SIZE.
REQ-006 Half load SHALL take lane i_byte_offset[1] (bits [16j+15:16j]); i_byte_offset[0] SHALL be ignored, with no misalignment trap.
REQ-007 Word load SHALL pass all IO_BUS_SIZE bits of i_mem_result and ignore offset and i_mem_unsigned.
REQ-008 The MEM/WB register SHALL update on each rising i_clk edge with priority reset > flush > stall > load.
REQ-009 On flush, the register SHALL take o_wb_en=0, o_wb_addr=0, o_wb_data=0.
REQ-010 On stall without flush, all outputs and o_retired SHALL hold.
REQ-011 On load, o_wb_data and o_wb_addr SHALL take the selected data and i_rd.
REQ-012 On load, o_wb_en SHALL take i_valid & i_reg_write & (i_rd != 0).
REQ-013 Latency SHALL be exactly 1 cycle from inputs to o_wb_*; there SHALL be no combinational path from inputs to outputs.
REQ-014 o_retired SHALL increment by 1 on each load cycle with i_valid=1, whether or not it writes a register, and SHALL wrap modulo 2^RETIRE_CNT_SIZE.
REQ-015 o_retired SHALL not change on stall, flush or reset-released idle cycles with i_valid=0.
REQ-016 When flush and stall are both asserted, flush SHALL win: a bubble is loaded and the counter is unchanged.

Reset
REQ-017 While i_reset=1 at a clock edge, o_wb_data, o_wb_addr, o_wb_en and o_retired SHALL all become 0, regardless of stall or flush.
REQ-018 Reset asserted mid-stall SHALL discard the held instruction; the first post-reset edge SHALL resume normal loading.

Structure
REQ-019 WB_SRC_ALU/MEM/LINK, MEM_SIZE_BYTE/HALF/WORD and the link offset (8) SHALL be defined in the shared MIPS constants package and used by both the decode stage and this block.
REQ-020 Load extraction SHALL be one combinational sub-module, load_extract (inputs: data, size, unsigned, offset; output: extended data), instantiated once.

Verification
REQ-021 Reset: i_reset=1 for 2 cycles with random inputs -> all outputs 0.
REQ-022 Loads, with i_mem_result=0x80FF7F01, MEM src, rd=5, valid, reg_write:
- byte, offset 3, signed -> 0xFFFFFF80 on next cycle, o_wb_addr=5, o_wb_en=1.
- byte, offset 3, unsigned -> 0x00000080.
- half, offset 2, signed -> 0xFFFF80FF.
- half, offset 1, signed -> 0x00007F01.
REQ-023 Link: i_pc=0xFFFFFFFC, LINK src, rd=31 -> o_wb_data=0x00000004, o_wb_en=1.
REQ-024 Stall: load ALU 0x12345678 to rd=3, then stall for 3 cycles with alu=0xDEADBEEF -> outputs hold 0x12345678/3/1 and o_retired stays 1; release -> 0xDEADBEEF, o_retired=2.
REQ-025 Bubbles and suppressed writes:
- flush=1 with stall=1 -> o_wb_en=0, o_wb_data=0, counter unchanged.
- valid, reg_write, rd=0 -> o_wb_en=0 but o_retired increments.
REQ-026 Wrap: RETIRE_CNT_SIZE=4, 17 consecutive valid loads -> o_retired=1.
